// File: rtl/alu_operand_loader_if.sv
// Purpose : switch/button inputs and operand/opcode outputs of the ALU operand loader.
// Latency : none, wiring only.
// Backpressure: none; the slave side drives the operands, the master side drives the switches and button.
// Ports   : i_sw/i_btn_load (board inputs), o_a/o_b/o_op/o_valid/o_err/o_state (to the ALU and LEDs).
interface alu_operand_loader_if #(
   parameter int N_BITS  = 8,
   parameter int OP_BITS = 6
);
   logic [N_BITS-1:0]  i_sw;
   logic               i_btn_load;
   logic [N_BITS-1:0]  o_a;
   logic [N_BITS-1:0]  o_b;
   logic [OP_BITS-1:0] o_op;
   logic               o_valid;
   logic               o_err;
   logic [1:0]         o_state;

   modport master (
      output i_sw, i_btn_load,
      input  o_a, o_b, o_op, o_valid, o_err, o_state
   );

   modport slave (
      input  i_sw, i_btn_load,
      output o_a, o_b, o_op, o_valid, o_err, o_state
   );
endinterface

// File: rtl/alu_operand_loader.sv
// Purpose : loads operand A, operand B and the opcode from the switches, one per debounced button press.
// Latency : capture lands DEBOUNCE_CYCLES+2 edges after the button is first sampled high.
// Backpressure: none; the ALU consumes o_a/o_b/o_op combinationally while o_valid is high.
// Ports   : clk, reset (sync, active-high), bus (slave modport: i_sw, i_btn_load in; o_a, o_b, o_op,
//           o_valid, o_err, o_state out).
module alu_operand_loader #(
   parameter int N_BITS          = 8,
   parameter int OP_BITS         = 6,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic                 clk,
   input logic                 reset,
   alu_operand_loader_if.slave bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      READY   = 2'd3
   } state_t;

   // Button conditioning
   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic             press;

   // Two-flop synchronizer, then a level is accepted only after it has
   // differed from the current debounced level for DEBOUNCE_CYCLES cycles
   // in a row. Only the rising change of the debounced level fires a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= bus.i_btn_load;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
            press  <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   function automatic logic op_supported(input logic [OP_BITS-1:0] op);
      case (op)
         OP_BITS'(6'b100000),   // ADD
         OP_BITS'(6'b100010),   // SUB
         OP_BITS'(6'b100100),   // AND
         OP_BITS'(6'b100101),   // OR
         OP_BITS'(6'b100110),   // XOR
         OP_BITS'(6'b100111),   // NOR
         OP_BITS'(6'b000011),   // SRA
         OP_BITS'(6'b000010):   // SRL
            return 1'b1;
         default:
            return 1'b0;
      endcase
   endfunction

   // Load FSM and operand registers
   state_t             state_q, state_d;
   logic [N_BITS-1:0]  a_q, a_d;
   logic [N_BITS-1:0]  b_q, b_d;
   logic [OP_BITS-1:0] op_q, op_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      err_d   = err_q;
      if (press) begin
         case (state_q)
            LOAD_A: begin
               a_d     = bus.i_sw;
               err_d   = 1'b0;
               state_d = LOAD_B;
            end
            LOAD_B: begin
               b_d     = bus.i_sw;
               state_d = LOAD_OP;
            end
            LOAD_OP: begin
               // A rejected opcode keeps the FSM here so the user can retry.
               if (op_supported(bus.i_sw[OP_BITS-1:0])) begin
                  op_d    = bus.i_sw[OP_BITS-1:0];
                  err_d   = 1'b0;
                  state_d = READY;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               // READY: next press starts a new operation; old B/OP stay visible.
               a_d     = bus.i_sw;
               state_d = LOAD_B;
            end
         endcase
      end
      // Registered so valid rises on the same edge that loads the opcode.
      valid_d = (state_d == READY);
   end

   assign bus.o_a     = a_q;
   assign bus.o_b     = b_q;
   assign bus.o_op    = op_q;
   assign bus.o_valid = valid_q;
   assign bus.o_err   = err_q;
   assign bus.o_state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Purpose : self-checking bench for alu_operand_loader against a behavioural model.
// Latency : n/a.
// Backpressure: n/a.
module tb_alu_operand_loader;

   localparam int DC = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_operand_loader_if #(.N_BITS(8), .OP_BITS(6)) bus();

   alu_operand_loader #(
      .N_BITS(8), .OP_BITS(6), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   bit started = 0;

   logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b100111, 6'b000011, 6'b000010};

   // Behavioural model
   logic       m_s1, m_s2, m_stable;
   bit         m_pulse;
   bit         since [$];      // synchronized levels seen since the last accepted change
   int         m_state;
   logic [7:0] m_a, m_b;
   logic [5:0] m_op;
   bit         m_err, m_valid;

   function automatic bit is_op(input logic [5:0] v);
      foreach (ops[k]) if (ops[k] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_capture(input logic [7:0] sw);
      case (m_state)
         0: begin m_a = sw; m_err = 0; m_state = 1; end
         1: begin m_b = sw; m_state = 2; end
         2: if (is_op(sw[5:0])) begin m_op = sw[5:0]; m_err = 0; m_state = 3; end
            else m_err = 1;
         default: begin m_a = sw; m_state = 1; end
      endcase
      m_valid = (m_state == 3);
   endtask

   // True when the last DC synchronized levels all disagree with the accepted level.
   function automatic bit window_differs();
      if (since.size() < DC) return 1'b0;
      for (int k = since.size() - DC; k < since.size(); k++)
         if (since[k] == m_stable) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_pulse = 0; since.delete();
         m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0; m_valid = 0;
      end else begin
         if (m_pulse) m_capture(bus.i_sw);
         m_pulse = 0;
         since.push_back(m_s2);
         if (since.size() > DC) void'(since.pop_front());
         if (window_differs()) begin
            m_stable = !m_stable;
            m_pulse  = m_stable;
            since.delete();
         end
         m_s2 = m_s1;
         m_s1 = bus.i_btn_load;
      end
   end

   // Cycle-by-cycle compare against the model.
   always @(negedge clk) begin
      if (started) begin
         logic [25:0] act, exp;
         act = {bus.o_a, bus.o_b, bus.o_op, bus.o_valid, bus.o_err, bus.o_state};
         exp = {m_a, m_b, m_op, m_valid, m_err, 2'(m_state)};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL model_cmp t=%0t got a=%h b=%h op=%b v=%b e=%b st=%0d want a=%h b=%h op=%b v=%b e=%b st=%0d",
                     $time, bus.o_a, bus.o_b, bus.o_op, bus.o_valid, bus.o_err, bus.o_state,
                     m_a, m_b, m_op, m_valid, m_err, m_state);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clean press whose capture must land on the 7th edge after first sample.
   task automatic timed_press(input logic [7:0] sw, input logic [1:0] st_before,
                              input logic [1:0] st_after);
      @(negedge clk);
      bus.i_sw = sw;
      bus.i_btn_load = 1'b1;
      repeat (DC + 2) @(posedge clk);
      #1 chk("pre_capture_state", 32'(bus.o_state), 32'(st_before));
      @(posedge clk);
      #1 chk("capture_state", 32'(bus.o_state), 32'(st_after));
      idle(4);
      bus.i_sw = 8'($urandom);     // held button, changing switches: no effect
      idle(8);
      bus.i_btn_load = 1'b0;
      idle(12);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      idle(n);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.i_btn_load = 1'b0;
      bus.i_sw = 8'h00;
      @(posedge clk);
      #1 started = 1;
      idle(2);
      chk("reset_state", 32'(bus.o_state), 32'd0);
      chk("reset_valid", 32'(bus.o_valid), 32'd0);
      chk("reset_a", 32'(bus.o_a), 32'd0);
      reset = 1'b0;
      idle(5);

      // Three clean loads.
      timed_press(8'b10110011, 2'd0, 2'd1);
      timed_press(8'd3,        2'd1, 2'd2);
      timed_press(8'b00000010, 2'd2, 2'd3);
      chk("t1_a",     32'(bus.o_a),     32'hB3);
      chk("t1_b",     32'(bus.o_b),     32'h03);
      chk("t1_op",    32'(bus.o_op),    32'h02);
      chk("t1_valid", 32'(bus.o_valid), 32'd1);

      // New operation from READY keeps old B/OP.
      timed_press(8'h0F, 2'd3, 2'd1);
      chk("t5_a",     32'(bus.o_a),     32'h0F);
      chk("t5_valid", 32'(bus.o_valid), 32'd0);
      chk("t5_b",     32'(bus.o_b),     32'h03);
      chk("t5_op",    32'(bus.o_op),    32'h02);

      // Unsupported then supported opcode.
      timed_press(8'h12, 2'd1, 2'd2);
      timed_press(8'h3F, 2'd2, 2'd2);
      chk("t3_err",  32'(bus.o_err), 32'd1);
      chk("t3_op",   32'(bus.o_op),  32'h02);
      timed_press(8'h20, 2'd2, 2'd3);
      chk("t3_err2",   32'(bus.o_err),   32'd0);
      chk("t3_op2",    32'(bus.o_op),    32'h20);
      chk("t3_valid2", 32'(bus.o_valid), 32'd1);

      // Bounce shorter than the debounce window is ignored.
      do_reset(2);
      idle(3);
      bus.i_btn_load = 1'b1; idle(1);
      bus.i_btn_load = 1'b0; idle(1);
      bus.i_btn_load = 1'b1; idle(1);
      bus.i_btn_load = 1'b0; idle(20);
      chk("t2_bounce_state", 32'(bus.o_state), 32'd0);
      bus.i_sw = 8'hA7;
      bus.i_btn_load = 1'b1; idle(20);
      chk("t2_hold_state", 32'(bus.o_state), 32'd1);
      chk("t2_hold_a", 32'(bus.o_a), 32'hA7);
      bus.i_btn_load = 1'b0; idle(12);

      // Reset mid-operation.
      do_reset(2);
      idle(3);
      timed_press(8'h55, 2'd0, 2'd1);
      timed_press(8'h01, 2'd1, 2'd2);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_a",     32'(bus.o_a),     32'd0);
      chk("t4_b",     32'(bus.o_b),     32'd0);
      chk("t4_op",    32'(bus.o_op),    32'd0);
      chk("t4_valid", 32'(bus.o_valid), 32'd0);
      chk("t4_state", 32'(bus.o_state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(3);

      // Button held through reset: one press after release of reset.
      bus.i_sw = 8'hC3;
      bus.i_btn_load = 1'b1;
      idle(3);
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      repeat (DC + 2) @(posedge clk);
      #1 chk("t6_pre_state", 32'(bus.o_state), 32'd0);
      @(posedge clk);
      #1 chk("t6_state", 32'(bus.o_state), 32'd1);
      chk("t6_a", 32'(bus.o_a), 32'hC3);
      idle(30);
      chk("t6_held_state", 32'(bus.o_state), 32'd1);
      bus.i_btn_load = 1'b0;
      idle(12);
      timed_press(8'h44, 2'd1, 2'd2);

      // Randomized phase: bouncy runs, changing switches, rare resets.
      for (int i = 0; i < 400; i++) begin
         int run;
         bus.i_btn_load = 1'($urandom_range(0, 1));
         run = (($urandom_range(0, 3)) == 0) ? $urandom_range(1, DC - 1)
                                             : $urandom_range(DC, 14);
         for (int j = 0; j < run; j++) begin
            if ($urandom_range(0, 1) == 0)
               bus.i_sw = {2'($urandom), ops[$urandom_range(0, 7)]};
            else
               bus.i_sw = 8'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            idle(1);
         end
      end
      reset = 1'b0;
      bus.i_btn_load = 1'b0;
      idle(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
